reflet_mem_responder: RTL and testbench
=======================================

# reflet_mem_responder

Bus responder for the Reflet CPU's flat memory interface: a synchronous word RAM with one-cycle read latency that answers the CPU's `addr` / `data_out` / `write_en` requests and returns data on the CPU's `data_in`. It also has an optional alignment-fault latch. The latch detects misaligned writes, drops them, records the faulting address, and raises an interrupt line meant for one bit of the CPU's `interrupt_request`. It sits beside (or replaces) the ROM in CPU test benches and small SoC tops.

## Interface
- `wordsize`, default 16: bus and word width in bits; legal values are 8, 16, 32, 64.
- `mem_words`, default 1024: RAM depth in words; must be a power of two.
- `fault_reg_addr`, default 16'hFFFE (sign-extended to `wordsize`): byte address of the fault register; must be word-aligned and outside the RAM range.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all registers except RAM contents.
- `enable`, in, 1: when low, no write commits, the fault state holds and `rdata` holds.
- `addr`, in, `wordsize`: byte address from the CPU.
- `wdata`, in, `wordsize`: write data (the CPU's `data_out`).
- `write_en`, in, 1: write strobe.
- `rdata`, out, `wordsize`: read data (drives the CPU's `data_in`); registered.
- `fault_irq`, out, 1: level interrupt; high while a fault is pending.

## Operation
- Lane bits: `lb = log2(wordsize/8)`. RAM word index is `addr[lb +: log2(mem_words)]`.
- Address decode, in priority order:
  - FAULT: `addr == fault_reg_addr`.
  - RAM: `addr < mem_words*wordsize/8`.
  - NONE: everything else.
- Read (every enabled cycle, independent of `write_en`):
  - RAM: `rdata` takes the word at the aligned-down address.
  - FAULT: `rdata` takes the latched fault address.
  - NONE: `rdata` takes 0.
- Writes are read-first: on a same-cycle write to the same word, `rdata` shows the old contents.
- Write to RAM: committed when `enable & write_en` and the address is aligned, i.e. `addr[lb-1:0]==0`. For `wordsize`=8 every address is aligned.
- Write to NONE: ignored, with no fault.
- Misaligned write (with the macro): the write is dropped. Then:
  - If no fault is pending, `fault_addr` is set to `addr` and `fault_irq` is set to 1.
  - If a fault is already pending, the first fault address is kept (sticky).
- Write of any value to FAULT: clears `fault_irq`. The `fault_addr` value is kept for later reads.
- A clear and a new misaligned write cannot occur in the same cycle, because both need `write_en` with different addresses. No arbitration is required.
- Misaligned reads never fault; they return the aligned-down word.

## Timing
- Read latency is 1 cycle. `addr` is sampled at edge N and `rdata` is valid after edge N. This matches the CPU's expectation of a clocked ROM.
- A write at edge N is visible to a read sampled at edge N+1.
- `fault_irq` rises after the edge that sampled the misaligned write, and falls after the edge that sampled the write to FAULT.
- Reset values: `rdata`=0, `fault_irq`=0, `fault_addr`=0.
- RAM contents are unaffected by reset, and are X until first written unless preloaded by the bench.
- Reset asserted mid-access: `rdata` and the fault state clear immediately. Any write sampled on the same edge as reset assertion is not guaranteed.
- `enable` low: no state changes at all, including `rdata`.

## Configuration
- `REFLET_MEM_ALIGN_TRAP_EN` defined: the fault latch, the FAULT decode and `fault_irq` behave as above.
- `REFLET_MEM_ALIGN_TRAP_EN` undefined:
  - Misaligned writes commit to the aligned-down word.
  - `fault_irq` is tied to 0.
  - FAULT is not decoded, so `fault_reg_addr` falls into RAM or NONE by normal decode.
  - No fault registers are synthesized.

## Structure
- Package `reflet_mem_pkg` holds:
  - function `lane_bits(wordsize)`;
  - region enum {REG_RAM, REG_FAULT, REG_NONE};
  - the default `fault_reg_addr` constant.
- Sub-module `reflet_fault_latch` (present only under the macro) holds the pending flag, the sticky address register and the set/clear logic.
- The top level holds the decode, the RAM array and the registered read mux.

## Test plan
- Aligned write then read: write 16'h1234 to 16'h0010, read 16'h0010 next cycle. Expect `rdata`=16'h1234 one cycle later, `fault_irq`=0.
- Read-first: write 16'hAAAA to 16'h0020, which holds 16'h5555, with the same address held. Expect `rdata`=16'h5555 after the write edge and 16'hAAAA one edge later.
- Misaligned write: write 16'hBEEF to 16'h0011. Expect `fault_irq`=1, word 16'h0010 unchanged, and a read of 16'hFFFE giving 16'h0011.
- Sticky fault and clear:
  - Misaligned writes to 16'h0011, then to 16'h0033. A read of 16'hFFFE gives 16'h0011.
  - Then write 0 to 16'hFFFE. Expect `fault_irq`=0, and 16'hFFFE still reads 16'h0011.
- Out of range and reset:
  - Write to 16'h9000, then read it. Expect `rdata`=0.
  - Assert `reset` with a fault pending. Expect `fault_irq` and `rdata` to go to 0 without waiting for a clock edge.
- Macro off: write 16'hBEEF to 16'h0011. Expect word 16'h0010 = 16'hBEEF and `fault_irq` stays 0.

Source files
------------

// File: rtl/reflet_mem_pkg.sv
// Shared types and constants for the Reflet flat-memory responder.
// Region decode enum, fault-latch state enum, lane-bit helper and default fault register address.
package reflet_mem_pkg;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_FAULT,
      REG_NONE
   } region_t;

   typedef enum logic {
      FLT_IDLE,
      FLT_PENDING
   } flt_state_t;

   // Sign-extended to the bus width at the point of use.
   localparam logic signed [15:0] FAULT_REG_ADDR_DFLT = 16'shFFFE;

   function automatic int lane_bits(input int wordsize);
      return $clog2(wordsize / 8);
   endfunction

endpackage

// File: rtl/reflet_mem_responder_if.sv
// Reflet CPU flat memory bus: request (addr/wdata/write_en/enable) and response (rdata/fault_irq).
// The master modport is the CPU side; the slave modport is the memory responder.
interface reflet_mem_responder_if #(
   parameter int wordsize = 16
);
   logic                enable;
   logic                write_en;
   logic [wordsize-1:0] addr;
   logic [wordsize-1:0] wdata;
   logic [wordsize-1:0] rdata;
   logic                fault_irq;

   modport master (
      output enable, write_en, addr, wdata,
      input  rdata, fault_irq
   );

   modport slave (
      input  enable, write_en, addr, wdata,
      output rdata, fault_irq
   );
endinterface

// File: rtl/reflet_fault_latch.sv
// Alignment-fault latch (REFLET_MEM_ALIGN_TRAP_EN builds only): pending flag plus sticky first-fault address.
// Set/clear take effect on the sampling edge; callers gate set/clr with the bus enable.
`ifdef REFLET_MEM_ALIGN_TRAP_EN
module reflet_fault_latch
   import reflet_mem_pkg::*;
#(
   parameter int wordsize = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                set,
   input  logic                clr,
   input  logic [wordsize-1:0] set_addr,
   output logic                pending,
   output logic [wordsize-1:0] fault_addr
);

   flt_state_t state_q, state_d;
   logic       capture;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FLT_IDLE;
      else       state_q <= state_d;
   end

   // set and clr are never both high: they need write_en on different addresses.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         FLT_IDLE: begin
            if (set) begin
               state_d = FLT_PENDING;
               capture = 1'b1;
            end
         end
         FLT_PENDING: begin
            if (clr) state_d = FLT_IDLE;
         end
         default: state_d = FLT_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        fault_addr <= '0;
      else if (capture) fault_addr <= set_addr;
   end

   assign pending = (state_q == FLT_PENDING);

endmodule
`endif

// File: rtl/reflet_mem_responder.sv
// Word RAM responder for the Reflet CPU bus: 1-cycle registered read, read-first writes, no stall.
// Alignment trap (fault latch, FAULT register decode, fault_irq) only when REFLET_MEM_ALIGN_TRAP_EN is defined.
module reflet_mem_responder
   import reflet_mem_pkg::*;
#(
   parameter int                  wordsize       = 16,
   parameter int                  mem_words      = 1024,
   parameter logic [wordsize-1:0] fault_reg_addr = wordsize'(FAULT_REG_ADDR_DFLT)
) (
   input  logic                   clk,
   input  logic                   reset,
   reflet_mem_responder_if.slave  bus
);

   localparam int                  LB        = lane_bits(wordsize);
   localparam int                  AW        = $clog2(mem_words);
   localparam logic [63:0]         RAM_BYTES = 64'(mem_words) * 64'(wordsize / 8);
   localparam logic [wordsize-1:0] LANE_MASK = wordsize'((64'd1 << LB) - 64'd1);

   if ((fault_reg_addr & LANE_MASK) != '0) begin : g_bad_fault_align
      $error("fault_reg_addr must be word-aligned");
   end

   logic [wordsize-1:0] mem [mem_words];
   logic [wordsize-1:0] rdata_q;
   logic [AW-1:0]       word_idx;
   logic                in_ram;
   logic                wr_req;
   logic                ram_we;
   region_t             region;

   // Index via shift so narrow buses with deep RAMs never slice past the address MSB.
   assign word_idx = AW'(64'(bus.addr) >> LB);
   assign in_ram   = (64'(bus.addr) < RAM_BYTES);
   assign wr_req   = bus.enable & bus.write_en;

   always_comb begin
      region = REG_NONE;
`ifdef REFLET_MEM_ALIGN_TRAP_EN
      if (bus.addr == fault_reg_addr) region = REG_FAULT;
      else if (in_ram)                region = REG_RAM;
`else
      if (in_ram) region = REG_RAM;
`endif
   end

`ifdef REFLET_MEM_ALIGN_TRAP_EN
   if (64'(fault_reg_addr) < RAM_BYTES) begin : g_bad_fault_range
      $error("fault_reg_addr must lie outside the RAM range");
   end

   logic                aligned;
   logic                flt_set;
   logic                flt_clr;
   logic                flt_pending;
   logic [wordsize-1:0] flt_addr;

   assign aligned = ((bus.addr & LANE_MASK) == '0);
   assign ram_we  = wr_req & (region == REG_RAM) & aligned;
   assign flt_set = wr_req & (region == REG_RAM) & ~aligned;
   assign flt_clr = wr_req & (region == REG_FAULT);

   reflet_fault_latch #(
      .wordsize (wordsize)
   ) u_fault_latch (
      .clk        (clk),
      .reset      (reset),
      .set        (flt_set),
      .clr        (flt_clr),
      .set_addr   (bus.addr),
      .pending    (flt_pending),
      .fault_addr (flt_addr)
   );

   assign bus.fault_irq = flt_pending;
`else
   // Without the trap, misaligned writes land on the aligned-down word.
   assign ram_we        = wr_req & (region == REG_RAM);
   assign bus.fault_irq = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (ram_we) mem[word_idx] <= wdata_word();
   end

   function automatic logic [wordsize-1:0] wdata_word();
      return bus.wdata;
   endfunction

   // Read-first: the registered read samples the array before this edge's write lands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (bus.enable) begin
         case (region)
            REG_RAM:   rdata_q <= mem[word_idx];
`ifdef REFLET_MEM_ALIGN_TRAP_EN
            REG_FAULT: rdata_q <= flt_addr;
`endif
            default:   rdata_q <= '0;
         endcase
      end
   end

   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_reflet_mem_responder.sv
// Directed bench for reflet_mem_responder (16-bit bus, 1024 words).
// Checks adapt to whether REFLET_MEM_ALIGN_TRAP_EN is defined for the build.
module tb_reflet_mem_responder;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   reflet_mem_responder_if #(.wordsize(16)) bus ();

   reflet_mem_responder #(
      .wordsize  (16),
      .mem_words (1024)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
      bus.enable   = 1'b1;
      bus.write_en = 1'b1;
      bus.addr     = a;
      bus.wdata    = d;
      tick();
      bus.write_en = 1'b0;
   endtask

   task automatic bus_rd(input logic [15:0] a);
      bus.enable   = 1'b1;
      bus.write_en = 1'b0;
      bus.addr     = a;
      tick();
   endtask

   initial begin
      reset        = 1'b1;
      bus.enable   = 1'b0;
      bus.write_en = 1'b0;
      bus.addr     = '0;
      bus.wdata    = '0;
      repeat (2) tick();
      check_val("reset_rdata", 64'(bus.rdata), 64'h0);
      check_val("reset_irq", 64'(bus.fault_irq), 64'h0);
      reset = 1'b0;

      // aligned write then read
      bus_wr(16'h0010, 16'h1234);
      bus_rd(16'h0010);
      check_val("wr_rd_0010", 64'(bus.rdata), 64'h1234);
      check_val("wr_rd_irq", 64'(bus.fault_irq), 64'h0);

      // read-first on same-address write
      bus_wr(16'h0020, 16'h5555);
      bus.addr     = 16'h0020;
      bus.wdata    = 16'hAAAA;
      bus.write_en = 1'b1;
      tick();
      check_val("read_first_old", 64'(bus.rdata), 64'h5555);
      bus.write_en = 1'b0;
      tick();
      check_val("read_first_new", 64'(bus.rdata), 64'hAAAA);

      // out of range write ignored, reads zero
      bus_wr(16'h9000, 16'h7777);
      bus_rd(16'h0010);
      check_val("pre_oor_0010", 64'(bus.rdata), 64'h1234);
      bus_rd(16'h9000);
      check_val("oor_read", 64'(bus.rdata), 64'h0);

      // enable low: rdata holds, write blocked
      bus_rd(16'h0020);
      bus.enable   = 1'b0;
      bus.addr     = 16'h0010;
      bus.wdata    = 16'h0000;
      bus.write_en = 1'b1;
      tick();
      check_val("en_low_hold", 64'(bus.rdata), 64'hAAAA);
      bus.write_en = 1'b0;
      bus_rd(16'h0010);
      check_val("en_low_no_wr", 64'(bus.rdata), 64'h1234);

      // misaligned read returns aligned-down word
      bus_rd(16'h0021);
      check_val("misaligned_rd", 64'(bus.rdata), 64'hAAAA);

`ifdef REFLET_MEM_ALIGN_TRAP_EN
      bus_wr(16'h0011, 16'hBEEF);
      check_val("mis_irq_set", 64'(bus.fault_irq), 64'h1);
      bus_rd(16'h0010);
      check_val("mis_dropped", 64'(bus.rdata), 64'h1234);
      bus_rd(16'hFFFE);
      check_val("fault_addr1", 64'(bus.rdata), 64'h0011);

      bus_wr(16'h0033, 16'h0000);
      check_val("sticky_irq", 64'(bus.fault_irq), 64'h1);
      bus_rd(16'hFFFE);
      check_val("sticky_addr", 64'(bus.rdata), 64'h0011);

      bus.enable   = 1'b0;
      bus.addr     = 16'hFFFE;
      bus.write_en = 1'b1;
      tick();
      check_val("en_low_no_clr", 64'(bus.fault_irq), 64'h1);
      bus.write_en = 1'b0;

      bus_wr(16'hFFFE, 16'h0000);
      check_val("clr_irq", 64'(bus.fault_irq), 64'h0);
      bus_rd(16'hFFFE);
      check_val("clr_keeps_addr", 64'(bus.rdata), 64'h0011);

      bus_wr(16'h0035, 16'h0001);
      check_val("rearm_irq", 64'(bus.fault_irq), 64'h1);
      bus_rd(16'hFFFE);
      check_val("rearm_addr", 64'(bus.rdata), 64'h0035);

      #2 reset = 1'b1;
      #1;
      check_val("async_rst_rdata", 64'(bus.rdata), 64'h0);
      check_val("async_rst_irq", 64'(bus.fault_irq), 64'h0);
      tick();
      reset = 1'b0;
      bus_rd(16'hFFFE);
      check_val("rst_fault_addr", 64'(bus.rdata), 64'h0);
      bus_rd(16'h0010);
      check_val("ram_kept", 64'(bus.rdata), 64'h1234);
`else
      bus_wr(16'h0011, 16'hBEEF);
      check_val("mis_no_irq", 64'(bus.fault_irq), 64'h0);
      bus_rd(16'h0010);
      check_val("mis_commits", 64'(bus.rdata), 64'hBEEF);
      bus_rd(16'hFFFE);
      check_val("fffe_is_none", 64'(bus.rdata), 64'h0);

      bus_rd(16'h0010);
      #2 reset = 1'b1;
      #1;
      check_val("async_rst_rdata", 64'(bus.rdata), 64'h0);
      check_val("async_rst_irq", 64'(bus.fault_irq), 64'h0);
      tick();
      reset = 1'b0;
      bus_rd(16'h0010);
      check_val("ram_kept", 64'(bus.rdata), 64'hBEEF);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
